pdecoder_seq: RTL and testbench

- Sequential counterpart of the lower-bit-first priority encoder (`pencoder`).
- Receives a stream of 3-bit bit indices over a valid/ready handshake, one index per beat, with the final beat flagged by `in_last`.
- Rebuilds the 8-bit vector the indices came from and presents it on a valid/ready output.
- Checks that each frame's indices arrive in strictly increasing order, which is the order the encoder emits them when iterated.

---
 rtl/pdecoder_seq_if.sv | 25 ++
 rtl/pdecoder_seq.sv | 84 ++++++++
 tb/tb_pdecoder_seq.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/pdecoder_seq_if.sv
// Handshake bundle for the sequential priority decoder: index beats in, vector out.
// The slave modport is the decoder's view; master is the source/sink side.
interface pdecoder_seq_if #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] in_idx;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_vec;
  logic             out_err;

  modport slave (
    input  in_valid, in_idx, in_last, out_ready,
    output in_ready, out_valid, out_vec, out_err
  );

  modport master (
    output in_valid, in_idx, in_last, out_ready,
    input  in_ready, out_valid, out_vec, out_err
  );
endinterface

// File: rtl/pdecoder_seq.sv
// Rebuilds a WIDTH-bit vector from a framed stream of ascending bit indices,
// flagging frames whose indices are out of range, repeated or descending.
module pdecoder_seq #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic          clk,
  input  logic          reset,
  pdecoder_seq_if.slave bus
);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] acc_reg;
  logic             err_acc_reg;
  logic             first_reg;
  logic [IDX_W-1:0] prev_idx_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] out_vec_reg;
  logic             out_err_reg;

  logic [WIDTH-1:0] onehot;
  logic             in_range;
  logic             bad;
  logic             accept;

  // An index past WIDTH-1 matches no bit, so it contributes nothing to the vector.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_onehot
    assign onehot[gi] = (int'(bus.in_idx) == gi);
  end

  assign in_range = (int'(bus.in_idx) < WIDTH);
  assign bad      = !in_range || (!first_reg && (bus.in_idx <= prev_idx_reg));
  assign accept   = bus.in_valid && (state_reg == ACCUM);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ACCUM;
      acc_reg       <= '0;
      err_acc_reg   <= 1'b0;
      first_reg     <= 1'b1;
      prev_idx_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_vec_reg   <= '0;
      out_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ACCUM: begin
          if (accept) begin
            if (bus.in_last) begin
              out_vec_reg   <= acc_reg | onehot;
              out_err_reg   <= err_acc_reg | bad;
              out_valid_reg <= 1'b1;
              state_reg     <= HOLD;
              acc_reg       <= '0;
              err_acc_reg   <= 1'b0;
              first_reg     <= 1'b1;
            end else begin
              acc_reg      <= acc_reg | onehot;
              err_acc_reg  <= err_acc_reg | bad;
              prev_idx_reg <= bus.in_idx;
              first_reg    <= 1'b0;
            end
          end
        end
        HOLD: begin
          // Output and its data stay frozen until the sink takes them.
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= ACCUM;
          end
        end
        default: state_reg <= ACCUM;
      endcase
    end
  end

  assign bus.in_ready  = (state_reg == ACCUM);
  assign bus.out_valid = out_valid_reg;
  assign bus.out_vec   = out_vec_reg;
  assign bus.out_err   = out_err_reg;

endmodule

// File: tb/tb_pdecoder_seq.sv
// Directed bench for pdecoder_seq: hand-computed frames, backpressure, reset
// mid-frame and a full round trip of every nonzero 8-bit vector.
module tb_pdecoder_seq;
  logic clk;
  logic reset;
  int   errors;
  int   checks;

  pdecoder_seq_if #(.WIDTH(8), .IDX_W(3)) intf ();

  pdecoder_seq #(.WIDTH(8), .IDX_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (intf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one beat and wait (bounded) until it is accepted at a rising edge.
  task automatic beat(input logic [2:0] idx, input logic last);
    int n;
    bit acc;
    intf.in_valid = 1'b1;
    intf.in_idx   = idx;
    intf.in_last  = last;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      @(posedge clk);
      acc = intf.in_valid && intf.in_ready;
      n++;
      #1;
    end
    intf.in_valid = 1'b0;
    intf.in_last  = 1'b0;
    chk("beat_accept", 32'(acc), 32'd1);
  endtask

  // Check a completed frame, then take it with a one-cycle out_ready pulse.
  task automatic expect_out(input string tag, input logic [7:0] vec, input logic err);
    chk({tag, "_valid"}, 32'(intf.out_valid), 32'd1);
    chk({tag, "_vec"}, 32'(intf.out_vec), 32'(vec));
    chk({tag, "_err"}, 32'(intf.out_err), 32'(err));
    intf.out_ready = 1'b1;
    @(posedge clk);
    #1;
    intf.out_ready = 1'b0;
    chk({tag, "_drop"}, 32'(intf.out_valid), 32'd0);
  endtask

  initial begin
    logic [7:0] tmp;
    int         low;
    bit         acc;
    errors = 0;
    checks = 0;
    intf.in_valid  = 1'b0;
    intf.in_idx    = '0;
    intf.in_last   = 1'b0;
    intf.out_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_in_ready", 32'(intf.in_ready), 32'd1);
    chk("rst_out_valid", 32'(intf.out_valid), 32'd0);
    chk("rst_out_vec", 32'(intf.out_vec), 32'h0);
    chk("rst_out_err", 32'(intf.out_err), 32'd0);

    // Frame 1,4,7 with the sink always ready
    intf.out_ready = 1'b1;
    beat(3'd1, 1'b0);
    beat(3'd4, 1'b0);
    beat(3'd7, 1'b1);
    chk("f147_valid", 32'(intf.out_valid), 32'd1);
    chk("f147_vec", 32'(intf.out_vec), 32'h92);
    chk("f147_err", 32'(intf.out_err), 32'd0);
    chk("f147_in_ready", 32'(intf.in_ready), 32'd0);
    @(posedge clk);
    #1;
    intf.out_ready = 1'b0;
    chk("f147_drop", 32'(intf.out_valid), 32'd0);
    chk("f147_rearm", 32'(intf.in_ready), 32'd1);

    beat(3'd0, 1'b1);
    expect_out("single0", 8'h01, 1'b0);
    beat(3'd7, 1'b1);
    expect_out("single7", 8'h80, 1'b0);

    beat(3'd5, 1'b0);
    beat(3'd2, 1'b1);
    expect_out("desc", 8'h24, 1'b1);
    beat(3'd3, 1'b0);
    beat(3'd3, 1'b1);
    expect_out("dup", 8'h08, 1'b1);
    beat(3'd6, 1'b1);
    expect_out("clean", 8'h40, 1'b0);

    // Backpressure with a pending beat stalled by HOLD
    beat(3'd2, 1'b1);
    intf.in_valid = 1'b1;
    intf.in_idx   = 3'd4;
    intf.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", 32'(intf.out_valid), 32'd1);
      chk("bp_vec", 32'(intf.out_vec), 32'h04);
      chk("bp_in_ready", 32'(intf.in_ready), 32'd0);
    end
    intf.out_ready = 1'b1;
    @(posedge clk);
    #1;
    intf.out_ready = 1'b0;
    chk("bp_drop", 32'(intf.out_valid), 32'd0);
    chk("bp_rearm", 32'(intf.in_ready), 32'd1);
    @(posedge clk);
    acc = intf.in_valid && intf.in_ready;
    #1;
    intf.in_valid = 1'b0;
    intf.in_last  = 1'b0;
    chk("bp_pending_accept", 32'(acc), 32'd1);
    expect_out("bp_pending", 8'h10, 1'b0);

    // Reset mid-frame discards the partial frame
    beat(3'd2, 1'b0);
    beat(3'd6, 1'b0);
    chk("mid_no_out", 32'(intf.out_valid), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("mid_rst_valid", 32'(intf.out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(intf.in_ready), 32'd1);
    beat(3'd0, 1'b1);
    expect_out("after_rst", 8'h01, 1'b0);

    // Round trip: lowest-set-bit-first encoding of every nonzero vector
    for (int v = 1; v < 256; v++) begin
      tmp = 8'(v);
      while (tmp != 8'h00) begin
        low = 0;
        for (int b = 7; b >= 0; b--) if (tmp[b]) low = b;
        tmp = tmp & (tmp - 8'd1);
        beat(3'(low), tmp == 8'h00);
      end
      expect_out($sformatf("rt_%02h", v), 8'(v), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
